// File: rtl/besthop_select.sv
// besthop_select
// Scans the per-neighbour Q-value table in node memory and finds the
// neighbour with the highest Q-value (besthop / best_q). It then picks the
// action neighbour by epsilon-greedy selection: exploit returns besthop, and
// explore reduces an LFSR byte modulo the neighbour count. The address bus
// only changes while a scan is in progress.
module besthop_select #(
   parameter int          WORD_WIDTH = 16,
   parameter logic [10:0] QBASE      = 11'h1C8,
   parameter int          MAX_NBR    = 128
) (
   input  logic                  clock,
   input  logic                  nrst,
   input  logic                  en,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] nbr_count,
   input  logic [7:0]            epsilon,
   input  logic [WORD_WIDTH-1:0] data_in,
   output logic [10:0]           address,
   output logic [WORD_WIDTH-1:0] besthop,
   output logic [WORD_WIDTH-1:0] action,
   output logic [WORD_WIDTH-1:0] best_q,
   output logic                  no_neighbor,
   output logic                  done
);

   // The neighbour index is 8 bits wide because the count is clamped to 128.
   localparam int                    IDX_W       = 8;
   localparam int                    PAD_W       = WORD_WIDTH - IDX_W;
   localparam logic [IDX_W-1:0]      MAX_NBR_IDX = IDX_W'(MAX_NBR);
   localparam logic [WORD_WIDTH-1:0] MAX_NBR_W   = WORD_WIDTH'(MAX_NBR);
   localparam logic [15:0]           LFSR_SEED   = 16'hACE1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_ADDR  = 3'd2,
      ST_CMP   = 3'd3,
      ST_SEL   = 3'd4,
      ST_MOD   = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   // One Fibonacci step. Taps 16, 14, 13 and 11 are fed back into the top
   // bit, and the register shifts right.
   function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
      logic fb;
      fb = cur[0] ^ cur[2] ^ cur[3] ^ cur[5];
      return {fb, cur[15:1]};
   endfunction

   // Zero-extends a neighbour index to the output word width.
   function automatic logic [WORD_WIDTH-1:0] widen_idx(input logic [IDX_W-1:0] idx);
      return {{PAD_W{1'b0}}, idx};
   endfunction

   state_t                state_r;
   state_t                state_nxt_s;

   logic [IDX_W-1:0]      idx_r;
   logic [IDX_W-1:0]      idx_nxt_s;
   logic [IDX_W-1:0]      idx_inc_s;
   logic [IDX_W-1:0]      nc_r;
   logic [IDX_W-1:0]      nc_nxt_s;
   logic [IDX_W-1:0]      rem_r;
   logic [IDX_W-1:0]      rem_nxt_s;
   logic [15:0]           lfsr_r;

   logic [10:0]           address_r;
   logic [10:0]           address_nxt_s;
   logic [WORD_WIDTH-1:0] besthop_r;
   logic [WORD_WIDTH-1:0] besthop_nxt_s;
   logic [WORD_WIDTH-1:0] action_r;
   logic [WORD_WIDTH-1:0] action_nxt_s;
   logic [WORD_WIDTH-1:0] best_q_r;
   logic [WORD_WIDTH-1:0] best_q_nxt_s;
   logic                  no_neighbor_r;
   logic                  no_neighbor_nxt_s;
   logic                  done_r;
   logic                  done_nxt_s;

   logic [IDX_W-1:0]      clamp_s;
   logic                  explore_s;
   logic                  q_better_s;
   logic                  last_entry_s;
   logic                  rem_wrap_s;
   logic [10:0]           entry_addr_s;

   // Requests larger than the table size are clamped to MAX_NBR.
   assign clamp_s      = (nbr_count > MAX_NBR_W) ? MAX_NBR_IDX : nbr_count[IDX_W-1:0];
   assign explore_s    = (lfsr_r[7:0] < epsilon);
   // The first entry always loads. After that, a strictly greater value is
   // needed, so on a tie the lower index is kept.
   assign q_better_s   = (idx_r == 8'd0) || (data_in > best_q_r);
   assign idx_inc_s    = idx_r + 8'd1;
   assign last_entry_s = (idx_inc_s == nc_r);
   assign rem_wrap_s   = (rem_r >= nc_r);
   // The entry stride is two bytes. With an 8-bit index the highest address is 0x2C6.
   assign entry_addr_s = QBASE + {2'b00, idx_r, 1'b0};
   assign done_nxt_s   = (state_nxt_s == ST_DONE);

   // State register.
   always_ff @(posedge clock) begin
      if (!nrst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode of the scan / select sequence.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (en) begin
               state_nxt_s = ST_ARMED;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ARMED: begin
            if (start) begin
               if (clamp_s == 8'd0) begin
                  state_nxt_s = ST_SEL;
               end else begin
                  state_nxt_s = ST_ADDR;
               end
            end else begin
               state_nxt_s = ST_ARMED;
            end
         end
         ST_ADDR: begin
            state_nxt_s = ST_CMP;
         end
         ST_CMP: begin
            if (last_entry_s) begin
               state_nxt_s = ST_SEL;
            end else begin
               state_nxt_s = ST_ADDR;
            end
         end
         ST_SEL: begin
            if (nc_r == 8'd0) begin
               state_nxt_s = ST_DONE;
            end else if (explore_s) begin
               state_nxt_s = ST_MOD;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         ST_MOD: begin
            if (rem_wrap_s) begin
               state_nxt_s = ST_MOD;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Per-state datapath updates. All outputs are held unless a state changes them.
   always_comb begin
      address_nxt_s     = address_r;
      besthop_nxt_s     = besthop_r;
      action_nxt_s      = action_r;
      best_q_nxt_s      = best_q_r;
      no_neighbor_nxt_s = no_neighbor_r;
      idx_nxt_s         = idx_r;
      nc_nxt_s          = nc_r;
      rem_nxt_s         = rem_r;
      case (state_r)
         ST_IDLE: begin
            if (en) begin
               address_nxt_s     = 11'h000;
               besthop_nxt_s     = {WORD_WIDTH{1'b0}};
               action_nxt_s      = {WORD_WIDTH{1'b0}};
               best_q_nxt_s      = {WORD_WIDTH{1'b0}};
               no_neighbor_nxt_s = 1'b0;
            end else begin
               address_nxt_s     = address_r;
            end
         end
         ST_ARMED: begin
            if (start) begin
               nc_nxt_s  = clamp_s;
               idx_nxt_s = 8'd0;
            end else begin
               nc_nxt_s  = nc_r;
            end
         end
         ST_ADDR: begin
            address_nxt_s = entry_addr_s;
         end
         ST_CMP: begin
            if (q_better_s) begin
               best_q_nxt_s  = data_in;
               besthop_nxt_s = widen_idx(idx_r);
            end else begin
               best_q_nxt_s  = best_q_r;
            end
            idx_nxt_s = idx_inc_s;
         end
         ST_SEL: begin
            if (nc_r == 8'd0) begin
               no_neighbor_nxt_s = 1'b1;
               besthop_nxt_s     = {WORD_WIDTH{1'b0}};
               action_nxt_s      = {WORD_WIDTH{1'b0}};
            end else if (explore_s) begin
               rem_nxt_s         = lfsr_r[15:8];
            end else begin
               action_nxt_s      = besthop_r;
            end
         end
         ST_MOD: begin
            // The modulo is done by repeated subtraction, one step per clock.
            if (rem_wrap_s) begin
               rem_nxt_s    = rem_r - nc_r;
            end else begin
               action_nxt_s = widen_idx(rem_r);
            end
         end
         ST_DONE: begin
            idx_nxt_s = idx_r;
         end
         default: begin
            idx_nxt_s = idx_r;
         end
      endcase
   end

   // Registered outputs and scan bookkeeping.
   always_ff @(posedge clock) begin
      if (!nrst) begin
         address_r     <= 11'h000;
         besthop_r     <= {WORD_WIDTH{1'b0}};
         action_r      <= {WORD_WIDTH{1'b0}};
         best_q_r      <= {WORD_WIDTH{1'b0}};
         no_neighbor_r <= 1'b0;
         done_r        <= 1'b0;
         idx_r         <= 8'd0;
         nc_r          <= 8'd0;
         rem_r         <= 8'd0;
      end else begin
         address_r     <= address_nxt_s;
         besthop_r     <= besthop_nxt_s;
         action_r      <= action_nxt_s;
         best_q_r      <= best_q_nxt_s;
         no_neighbor_r <= no_neighbor_nxt_s;
         done_r        <= done_nxt_s;
         idx_r         <= idx_nxt_s;
         nc_r          <= nc_nxt_s;
         rem_r         <= rem_nxt_s;
      end
   end

   // The exploration LFSR advances on every clock that is not a reset clock, in every state.
   always_ff @(posedge clock) begin
      if (!nrst) begin
         lfsr_r <= LFSR_SEED;
      end else begin
         lfsr_r <= lfsr_step(lfsr_r);
      end
   end

   assign address     = address_r;
   assign besthop     = besthop_r;
   assign action      = action_r;
   assign best_q      = best_q_r;
   assign no_neighbor = no_neighbor_r;
   assign done        = done_r;

endmodule

// File: tb/tb_besthop_select.sv
// Self-checking bench for besthop_select: a table of directed scans,
// hand-written reset/handshake sequences, and randomized scans checked
// against a behavioural reference model.
module tb_besthop_select;
   localparam logic [10:0] QBASE = 11'h1C8;

   logic        clock;
   logic        nrst;
   logic        en;
   logic        start;
   logic [15:0] nbr_count;
   logic [7:0]  epsilon;
   logic [15:0] data_in;
   logic [10:0] address;
   logic [15:0] besthop;
   logic [15:0] action;
   logic [15:0] best_q;
   logic        no_neighbor;
   logic        done;

   int checks = 0;
   int errors = 0;

   logic [15:0] qmem [0:127];
   logic [15:0] m_lfsr;
   logic [10:0] mem_off;

   typedef struct {
      int          done_edge;
      int          reads;
      logic [15:0] bh;
      logic [15:0] bq;
      logic [15:0] act;
      logic        nn;
   } exp_t;

   typedef struct {
      int          done_edge;
      int          done_cycles;
      int          reads;
      int          seq_errs;
      logic [10:0] last_addr;
      logic [15:0] bh;
      logic [15:0] bq;
      logic [15:0] act;
      logic [15:0] hold_bh;
      logic        nn;
   } obs_t;

   typedef struct {
      logic [15:0]       n;
      logic [3:0][15:0]  q;
      logic [15:0]       bh;
      logic [15:0]       bq;
      logic [15:0]       act;
      logic              nn;
      int                done_edge;
      int                reads;
   } vec_t;

   besthop_select #(.WORD_WIDTH(16), .QBASE(11'h1C8), .MAX_NBR(128)) dut (
      .clock       (clock),
      .nrst        (nrst),
      .en          (en),
      .start       (start),
      .nbr_count   (nbr_count),
      .epsilon     (epsilon),
      .data_in     (data_in),
      .address     (address),
      .besthop     (besthop),
      .action      (action),
      .best_q      (best_q),
      .no_neighbor (no_neighbor),
      .done        (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Node memory: the Q table answers in the Q region, and anything else reads as a marker.
   assign mem_off = address - QBASE;
   always_comb begin
      if (address >= QBASE && mem_off < 11'd256 && !mem_off[0]) data_in = qmem[mem_off[7:1]];
      else data_in = 16'hDEAD;
   end

   // Advances the LFSR by 'steps'. Feedback is the XOR of taps 16,14,13,11 (bits 0,2,3,5).
   function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int steps);
      logic [15:0] x;
      x = v;
      for (int s = 0; s < steps; s++) x = {^(x & 16'h002D), x[15:1]};
      return x;
   endfunction

   // Reference LFSR: it follows the reset and free-running rule.
   always @(posedge clock) begin
      if (!nrst) m_lfsr <= 16'hACE1;
      else m_lfsr <= lfsr_adv(m_lfsr, 1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: max Q and its lowest index, then epsilon-greedy on the LFSR value seen in SEL.
   task automatic predict(input logic [15:0] n, input logic [7:0] eps, input logic [15:0] l0,
                          output exp_t e);
      int          nc;
      int          r;
      logic [15:0] top;
      logic [15:0] sel;
      nc  = (n > 16'd128) ? 128 : int'(n);
      top = 16'h0000;
      for (int j = 0; j < nc; j++) if (qmem[j] > top) top = qmem[j];
      e.bh = 16'h0000;
      for (int j = nc - 1; j >= 0; j--) if (qmem[j] == top) e.bh = 16'(j);
      e.bq    = top;
      e.reads = nc;
      e.nn    = (nc == 0);
      sel     = lfsr_adv(l0, 2 * nc);
      if (nc == 0) begin
         e.act = 16'h0000; e.done_edge = 1;
      end else if (sel[7:0] < eps) begin
         r = int'(sel[15:8]);
         e.act = 16'(r % nc);
         e.done_edge = 2 * nc + 2 + r / nc;
      end else begin
         e.act = e.bh; e.done_edge = 2 * nc + 1;
      end
   endtask

   // Arms the block, starts one scan, and records everything up to a few cycles after done.
   task automatic run_scan(input logic [15:0] n, input logic [7:0] eps, output obs_t o,
                           output logic [15:0] l0);
      logic [10:0] prev;
      logic [10:0] seen[$];
      int          k;
      @(negedge clock); en = 1'b1; epsilon = eps;
      @(negedge clock); en = 1'b0; start = 1'b1; nbr_count = n;
      @(negedge clock); start = 1'b0;
      l0 = m_lfsr;
      chk("arm_clear_addr", address, 11'h000);
      chk("arm_clear_bq", best_q, 16'h0000);
      chk("arm_clear_nn", no_neighbor, 1'b0);
      prev = address;
      o.done_edge = -1; o.done_cycles = 0; o.seq_errs = 0; o.last_addr = 11'h000;
      o.bh = 16'hBAD0; o.bq = 16'hBAD0; o.act = 16'hBAD0; o.nn = 1'bx;
      k = 0;
      while (k < 400 && !(o.done_edge > 0 && k >= o.done_edge + 3)) begin
         @(posedge clock); @(negedge clock); k++;
         if (address !== prev) begin seen.push_back(address); prev = address; end
         if (done === 1'b1) begin
            o.done_cycles++;
            if (o.done_edge < 0) begin
               o.done_edge = k; o.bh = besthop; o.bq = best_q; o.act = action; o.nn = no_neighbor;
            end
         end
      end
      if (o.done_edge < 0) $display("FAIL scan_timeout: got no done within %0d edges", k);
      o.hold_bh = besthop;
      o.reads   = seen.size();
      foreach (seen[j]) if (seen[j] !== QBASE + 11'(2 * j)) o.seq_errs++;
      if (seen.size() > 0) o.last_addr = seen[seen.size() - 1];
   endtask

   task automatic compare(input string tag, input obs_t o, input exp_t e);
      chk({tag, "_done_edge"}, o.done_edge, e.done_edge);
      chk({tag, "_done_cycles"}, o.done_cycles, 1);
      chk({tag, "_besthop"}, o.bh, e.bh);
      chk({tag, "_best_q"}, o.bq, e.bq);
      chk({tag, "_action"}, o.act, e.act);
      chk({tag, "_no_neighbor"}, o.nn, e.nn);
      chk({tag, "_reads"}, o.reads, e.reads);
      chk({tag, "_addr_seq"}, o.seq_errs, 0);
      chk({tag, "_hold_besthop"}, o.hold_bh, e.bh);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t        tbl [6];
      obs_t        o;
      exp_t        e;
      logic [15:0] l0;
      int          pulses;

      tbl[0] = '{n:16'd4, q:{16'h0003, 16'h0009, 16'h0009, 16'h0005}, bh:16'd1, bq:16'd9,
                 act:16'd1, nn:1'b0, done_edge:9, reads:4};
      tbl[1] = '{n:16'd0, q:{16'h0001, 16'h0002, 16'h0003, 16'h0004}, bh:16'd0, bq:16'd0,
                 act:16'd0, nn:1'b1, done_edge:1, reads:0};
      tbl[2] = '{n:16'd4, q:{16'hFFFF, 16'h0003, 16'h0002, 16'h0001}, bh:16'd3, bq:16'hFFFF,
                 act:16'd3, nn:1'b0, done_edge:9, reads:4};
      tbl[3] = '{n:16'd1, q:{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0007}, bh:16'd0, bq:16'd7,
                 act:16'd0, nn:1'b0, done_edge:3, reads:1};
      tbl[4] = '{n:16'd3, q:{16'hFFFF, 16'h8000, 16'h7FFF, 16'h8000}, bh:16'd0, bq:16'h8000,
                 act:16'd0, nn:1'b0, done_edge:7, reads:3};
      tbl[5] = '{n:16'd4, q:{16'h0002, 16'h0002, 16'h0002, 16'h0002}, bh:16'd0, bq:16'd2,
                 act:16'd0, nn:1'b0, done_edge:9, reads:4};

      nrst = 1'b0; en = 1'b0; start = 1'b0; nbr_count = 16'd0; epsilon = 8'd0;
      for (int j = 0; j < 128; j++) qmem[j] = 16'hFFFF;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("reset_address", address, 11'h000);
      chk("reset_besthop", besthop, 16'h0000);
      chk("reset_action", action, 16'h0000);
      chk("reset_best_q", best_q, 16'h0000);
      chk("reset_no_neighbor", no_neighbor, 1'b0);
      chk("reset_done", done, 1'b0);
      nrst = 1'b1;

      // Directed exploit table (epsilon = 0). The entries past N hold 0xFFFF to expose over-reads.
      for (int t = 0; t < 6; t++) begin
         for (int j = 0; j < 128; j++) qmem[j] = (j < 4) ? tbl[t].q[j] : 16'hFFFF;
         run_scan(tbl[t].n, 8'd0, o, l0);
         e.done_edge = tbl[t].done_edge; e.reads = tbl[t].reads; e.bh = tbl[t].bh;
         e.bq = tbl[t].bq; e.act = tbl[t].act; e.nn = tbl[t].nn;
         compare($sformatf("vec%0d", t), o, e);
      end

      // Clamp: N = 300 reads 128 entries and ends at 0x2C6.
      for (int j = 0; j < 128; j++) qmem[j] = 16'h0000;
      run_scan(16'd300, 8'd0, o, l0);
      e.done_edge = 257; e.reads = 128; e.bh = 16'd0; e.bq = 16'd0; e.act = 16'd0; e.nn = 1'b0;
      compare("clamp", o, e);
      chk("clamp_last_addr", o.last_addr, 11'h2C6);

      // Explore path with epsilon = 255 and N = 3.
      for (int j = 0; j < 128; j++) qmem[j] = 16'($urandom_range(0, 50));
      run_scan(16'd3, 8'd255, o, l0);
      predict(16'd3, 8'd255, l0, e);
      compare("explore3", o, e);

      // Reset during CMP of entry 2 of 4. The reset must clear everything.
      for (int j = 0; j < 128; j++) qmem[j] = 16'hFFFF;
      qmem[0] = 16'd4; qmem[1] = 16'd8; qmem[2] = 16'd2; qmem[3] = 16'd6;
      @(negedge clock); en = 1'b1; epsilon = 8'd0;
      @(negedge clock); en = 1'b0; start = 1'b1; nbr_count = 16'd4;
      @(negedge clock); start = 1'b0;
      repeat (5) @(posedge clock);
      @(negedge clock); nrst = 1'b0;
      @(negedge clock); nrst = 1'b1;
      chk("midrst_address", address, 11'h000);
      chk("midrst_besthop", besthop, 16'h0000);
      chk("midrst_best_q", best_q, 16'h0000);
      chk("midrst_action", action, 16'h0000);
      chk("midrst_done", done, 1'b0);

      // While the block is IDLE with en low, start must have no effect.
      pulses = 0;
      start = 1'b1;
      repeat (8) begin
         @(negedge clock);
         if (done === 1'b1 || address !== 11'h000) pulses++;
      end
      start = 1'b0;
      chk("idle_start_ignored", pulses, 0);

      run_scan(16'd4, 8'd0, o, l0);
      e.done_edge = 9; e.reads = 4; e.bh = 16'd1; e.bq = 16'd8; e.act = 16'd1; e.nn = 1'b0;
      compare("after_rst", o, e);

      // Randomized scans against the reference model.
      for (int t = 0; t < 24; t++) begin
         logic [15:0] n;
         logic [7:0]  eps;
         if (t % 6 == 5) n = 16'($urandom_range(120, 400));
         else n = 16'($urandom_range(0, 9));
         if (t % 3 == 0) eps = 8'd255;
         else eps = 8'($urandom_range(0, 255));
         for (int j = 0; j < 128; j++) qmem[j] = (t % 2 == 1) ? 16'($urandom_range(0, 3)) : 16'($urandom);
         run_scan(n, eps, o, l0);
         predict(n, eps, l0, e);
         compare($sformatf("rnd%0d", t), o, e);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/besthop_select.md
# besthop_select

Upstream neighbour of the reward stage in the routing-agent datapath. Scans the per-neighbour Q-value table in shared node memory, picks the neighbour with the highest Q-value (`besthop`), and chooses the `action` neighbour index by epsilon-greedy selection. The reward stage consumes both to build its outgoing packet. The block owns the memory address bus only while it is scanning.

## Interface
Parameters:
- `WORD_WIDTH`, 16: data width of the memory word, Q-values and indices.
- `QBASE`, 11'h1C8: byte address of Q-value entry 0; entry stride is 2.
- `MAX_NBR`, 128: maximum neighbour count; larger requests are clamped to this.

Ports:
- `clock`  in  1  system clock, rising edge.
- `nrst`  in  1  reset, synchronous, active-low.
- `en`  in  1  arms the block from IDLE.
- `start`  in  1  starts a scan when ARMED.
- `nbr_count`  in  16  number of valid neighbours N, sampled with `start`.
- `epsilon`  in  8  exploration threshold, sampled in SEL.
- `data_in`  in  16  memory read data.
- `address`  out  11  registered memory byte address.
- `besthop`  out  16  index of the maximum-Q neighbour.
- `action`  out  16  chosen neighbour index.
- `best_q`  out  16  Q-value of `besthop`.
- `no_neighbor`  out  1  set when N == 0.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE(0), ARMED(1), ADDR(2), CMP(3), SEL(4), MOD(5), DONE(6). Unused encodings go to IDLE.
- IDLE: if `en`, go to ARMED and clear `besthop`, `action`, `best_q`, `no_neighbor`, `done`, `address`. Otherwise stay in IDLE.
- ARMED: `start` latches Nc = min(`nbr_count`, 128) and sets i = 0.
  - If Nc == 0, go to SEL.
  - Otherwise go to ADDR.
  - Without `start`, stay in ARMED.
- ADDR: set `address` = QBASE + {i, 1'b0} (8-bit i; maximum address 0x2C6), then go to CMP.
- CMP: sample `data_in` as q.
  - If i == 0 or q > `best_q` (unsigned compare), load `best_q` = q and `besthop` = i. Ties keep the lower index.
  - Increment i. If i == Nc, go to SEL; otherwise go to ADDR.
- SEL:
  - If Nc == 0: set `no_neighbor` = 1, `besthop` = 0, `action` = 0, and go to DONE.
  - Else if `lfsr[7:0]` < `epsilon`: explore. Load r = `lfsr[15:8]` and go to MOD.
  - Else: set `action` = `besthop` and go to DONE.
- MOD: iterative modulo.
  - If r ≥ Nc, r = r − Nc and stay in MOD.
  - Otherwise set `action` = r and go to DONE.
- DONE: `done` = 1 for this cycle only, then go to IDLE. `done` is cleared on leaving DONE.
- LFSR: 16-bit Fibonacci, taps 16, 14, 13, 11, seed 16'hACE1 on reset. It advances every non-reset clock in every state.
- `epsilon` = 0 never explores. `epsilon` = 255 explores unless `lfsr[7:0]` == 255.
- `en` and `start` are ignored outside IDLE and ARMED respectively. Deasserting `en` mid-scan does not abort the scan.
- Outputs hold their DONE values through IDLE until the next IDLE→ARMED transition clears them.

## Timing
- Reset (`nrst` = 0 at an edge) forces state IDLE and sets `address`, `besthop`, `action`, `best_q` = 0, `no_neighbor` = 0, `done` = 0, LFSR = 16'hACE1. This applies from any state, including mid-scan and mid-MOD.
- Memory read: `data_in` must be valid for the address registered at edge k when it is sampled at edge k+1.
- Edge numbering: E0 is the edge that samples `start` in ARMED.
  - The entry-i address is registered at E(2i+1) and its data is sampled at E(2i+2).
  - SEL is entered at E(2N).
  - Exploit path: `done` is high in the cycle after E(2N+1).
  - Explore path: add 1 + (number of subtractions) edges; bounded by 256 for N = 1.
  - N == 0: SEL at E0, `done` after E1.
- `besthop`, `action`, `best_q` and `no_neighbor` are valid no later than the cycle `done` is high.

## Test plan
- Exploit, basic: Q table [5, 9, 9, 3] at 0x1C8..0x1CE, N = 4, `epsilon` = 0.
  - Expect `besthop` = 1, `action` = 1, `best_q` = 9.
  - Expect `done` high exactly one cycle, 9 edges after E0.
  - Expect address sequence 0x1C8, 0x1CA, 0x1CC, 0x1CE.
- No neighbours: N = 0.
  - Expect `no_neighbor` = 1, `besthop` = `action` = 0, `done` after E1, and no change on `address`.
- Clamp and zero Q: N = 300 with all Q = 0.
  - Expect 128 reads, last `address` = 0x2C6, `besthop` = 0, `best_q` = 0.
- Explore: `epsilon` = 255, N = 3. Force the LFSR so that `lfsr` = 16'h0A00 in SEL.
  - Expect r = 10 → 7 → 4 → 1, then `action` = 1.
  - Expect 4 MOD edges; `besthop` is unaffected.
- Reset mid-scan: assert `nrst` = 0 during CMP of entry 2 of 4.
  - Expect all outputs 0 and state IDLE.
  - A following `en`/`start` completes correctly.
- Handshake: `start` asserted in IDLE (with `en` = 0) is ignored. Dropping `en` during ADDR still yields a normal `done`.
